// File: rtl/tetris_pkg.sv
// Shared playfield geometry, offset widths and placer FSM states.
package tetris_pkg;

  localparam int unsigned BOARD_ROWS_DEF = 20;
  localparam int unsigned BOARD_COLS_DEF = 10;
  localparam int unsigned ROW_AW_DEF     = 5;
  localparam int unsigned PIVOT_W        = 5;
  localparam int unsigned OFFSET_W       = 5;
  localparam int unsigned COORD_W        = 7;
  localparam int unsigned NUM_BLKS       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_RD,
    ST_EVAL,
    ST_WR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/tetron_cell_addr.sv
// Pivot + sign-extended offset adder producing a board cell and its bounds flag.
module tetron_cell_addr
  import tetris_pkg::*;
#(
  parameter int unsigned BOARD_ROWS = BOARD_ROWS_DEF,
  parameter int unsigned BOARD_COLS = BOARD_COLS_DEF,
  parameter int unsigned ROW_AW     = ROW_AW_DEF,
  parameter int unsigned COL_AW     = $clog2(BOARD_COLS_DEF)
) (
  input  logic [PIVOT_W-1:0]  piece_row,
  input  logic [PIVOT_W-1:0]  piece_col,
  input  logic [OFFSET_W-1:0] voffset,
  input  logic [OFFSET_W-1:0] hoffset,
  output logic [ROW_AW-1:0]   row,
  output logic [COL_AW-1:0]   col,
  output logic                oob
);

  localparam logic signed [COORD_W-1:0] ROWS_S = COORD_W'(BOARD_ROWS);
  localparam logic signed [COORD_W-1:0] COLS_S = COORD_W'(BOARD_COLS);

  logic signed [COORD_W-1:0] row_s;
  logic signed [COORD_W-1:0] col_s;

  // Signed cell coordinate and bounds test against walls and floor
  always_comb begin
    row_s = $signed({{(COORD_W-PIVOT_W){1'b0}}, piece_row})
          + $signed({{(COORD_W-OFFSET_W){voffset[OFFSET_W-1]}}, voffset});
    col_s = $signed({{(COORD_W-PIVOT_W){1'b0}}, piece_col})
          + $signed({{(COORD_W-OFFSET_W){hoffset[OFFSET_W-1]}}, hoffset});
    oob   = row_s[COORD_W-1] || (row_s >= ROWS_S)
         || col_s[COORD_W-1] || (col_s >= COLS_S);
    row   = row_s[ROW_AW-1:0];
    col   = col_s[COL_AW-1:0];
  end

endmodule

// File: rtl/tetron_board_placer.sv
// Applies four tetron block offsets to the board RAM: collision CHECK or lock-down COMMIT.
module tetron_board_placer
  import tetris_pkg::*;
#(
  parameter int unsigned BOARD_ROWS = BOARD_ROWS_DEF,
  parameter int unsigned BOARD_COLS = BOARD_COLS_DEF,
  parameter int unsigned ROW_AW     = ROW_AW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  commit,
  input  logic [PIVOT_W-1:0]    piece_row,
  input  logic [PIVOT_W-1:0]    piece_col,
  input  logic [OFFSET_W-1:0]   blk1_voffset,
  input  logic [OFFSET_W-1:0]   blk1_hoffset,
  input  logic [OFFSET_W-1:0]   blk2_voffset,
  input  logic [OFFSET_W-1:0]   blk2_hoffset,
  input  logic [OFFSET_W-1:0]   blk3_voffset,
  input  logic [OFFSET_W-1:0]   blk3_hoffset,
  input  logic [OFFSET_W-1:0]   blk4_voffset,
  input  logic [OFFSET_W-1:0]   blk4_hoffset,
  output logic                  busy,
  output logic                  done,
  output logic                  collision,
  output logic [ROW_AW-1:0]     board_rd_addr,
  input  logic [BOARD_COLS-1:0] board_rd_data,
  output logic                  board_wr_en,
  output logic [ROW_AW-1:0]     board_wr_addr,
  output logic [BOARD_COLS-1:0] board_wr_data
);

  localparam int unsigned COL_AW = $clog2(BOARD_COLS);
  localparam int unsigned BLK_W  = $clog2(NUM_BLKS);

  state_e              state;
  logic                commit_q;
  logic [PIVOT_W-1:0]  prow_q;
  logic [PIVOT_W-1:0]  pcol_q;
  logic [OFFSET_W-1:0] voff_q [NUM_BLKS];
  logic [OFFSET_W-1:0] hoff_q [NUM_BLKS];
  logic [BLK_W-1:0]    blk_idx;
  logic [COL_AW-1:0]   col_q;

  logic [ROW_AW-1:0]     cell_row;
  logic [COL_AW-1:0]     cell_col;
  logic                  cell_oob;
  logic                  last_blk;
  logic                  hit;
  logic [BOARD_COLS-1:0] col_mask;

  tetron_cell_addr #(
    .BOARD_ROWS (BOARD_ROWS),
    .BOARD_COLS (BOARD_COLS),
    .ROW_AW     (ROW_AW),
    .COL_AW     (COL_AW)
  ) u_cell_addr (
    .piece_row (prow_q),
    .piece_col (pcol_q),
    .voffset   (voff_q[blk_idx]),
    .hoffset   (hoff_q[blk_idx]),
    .row       (cell_row),
    .col       (cell_col),
    .oob       (cell_oob)
  );

  // Per-block helpers: last-block flag, occupancy of the target cell, write mask
  always_comb begin
    last_blk = (blk_idx == BLK_W'(NUM_BLKS - 1));
    hit      = board_rd_data[col_q];
    col_mask = '0;
    col_mask[col_q] = 1'b1;
  end

  // Placer FSM: one CALC/RD/EVAL(/WR) pass per block, registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      commit_q      <= 1'b0;
      prow_q        <= '0;
      pcol_q        <= '0;
      for (int unsigned i = 0; i < NUM_BLKS; i++) begin
        voff_q[i] <= '0;
        hoff_q[i] <= '0;
      end
      blk_idx       <= '0;
      col_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      collision     <= 1'b0;
      board_rd_addr <= '0;
      board_wr_en   <= 1'b0;
      board_wr_addr <= '0;
      board_wr_data <= '0;
    end else begin
      done        <= 1'b0;
      board_wr_en <= 1'b0;
      case (state)
        // DONE already has busy low, so a new request is accepted there too
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (start) begin
            commit_q  <= commit;
            prow_q    <= piece_row;
            pcol_q    <= piece_col;
            voff_q[0] <= blk1_voffset;
            hoff_q[0] <= blk1_hoffset;
            voff_q[1] <= blk2_voffset;
            hoff_q[1] <= blk2_hoffset;
            voff_q[2] <= blk3_voffset;
            hoff_q[2] <= blk3_hoffset;
            voff_q[3] <= blk4_voffset;
            hoff_q[3] <= blk4_hoffset;
            collision <= 1'b0;
            blk_idx   <= '0;
            busy      <= 1'b1;
            state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (cell_oob) begin
            collision <= 1'b1;
            if (!commit_q || last_blk) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              blk_idx <= blk_idx + 1'b1;
              state   <= ST_CALC;
            end
          end else begin
            board_rd_addr <= cell_row;
            col_q         <= cell_col;
            state         <= ST_RD;
          end
        end
        ST_RD: state <= ST_EVAL;
        ST_EVAL: begin
          if (commit_q) begin
            if (hit) collision <= 1'b1;
            board_wr_addr <= board_rd_addr;
            board_wr_data <= board_rd_data | col_mask;
            board_wr_en   <= 1'b1;
            state         <= ST_WR;
          end else if (hit || last_blk) begin
            if (hit) collision <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            blk_idx <= blk_idx + 1'b1;
            state   <= ST_CALC;
          end
        end
        ST_WR: begin
          if (last_blk) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            blk_idx <= blk_idx + 1'b1;
            state   <= ST_CALC;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tetron_board_placer.sv
// Directed-vector bench for tetron_board_placer with a registered-read board RAM.
module tb_tetron_board_placer;

  localparam logic [4:0] M1 = 5'h1F;  // -1
  localparam logic [4:0] P1 = 5'h01;
  localparam logic [4:0] P2 = 5'h02;
  localparam logic [4:0] P3 = 5'h03;
  localparam logic [4:0] Z  = 5'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       commit = 1'b0;
  logic [4:0] piece_row = '0;
  logic [4:0] piece_col = '0;
  logic [4:0] voff [4];
  logic [4:0] hoff [4];
  logic       busy, done, collision;
  logic [4:0] board_rd_addr;
  logic [9:0] board_rd_data;
  logic       board_wr_en;
  logic [4:0] board_wr_addr;
  logic [9:0] board_wr_data;

  logic [9:0] ram [32];
  logic       clr = 1'b0;
  logic       ld_en = 1'b0;
  logic [4:0] ld_addr = '0;
  logic [9:0] ld_data = '0;
  int         wr_total = 0;
  int         rd20_total = 0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tetron_board_placer #(
    .BOARD_ROWS (20),
    .BOARD_COLS (10),
    .ROW_AW     (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .commit        (commit),
    .piece_row     (piece_row),
    .piece_col     (piece_col),
    .blk1_voffset  (voff[0]),
    .blk1_hoffset  (hoff[0]),
    .blk2_voffset  (voff[1]),
    .blk2_hoffset  (hoff[1]),
    .blk3_voffset  (voff[2]),
    .blk3_hoffset  (hoff[2]),
    .blk4_voffset  (voff[3]),
    .blk4_hoffset  (hoff[3]),
    .busy          (busy),
    .done          (done),
    .collision     (collision),
    .board_rd_addr (board_rd_addr),
    .board_rd_data (board_rd_data),
    .board_wr_en   (board_wr_en),
    .board_wr_addr (board_wr_addr),
    .board_wr_data (board_wr_data)
  );

  // Single-port board RAM: one-cycle read latency, bench-side clear/preload port
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) ram[i] <= '0;
    end else if (ld_en) begin
      ram[ld_addr] <= ld_data;
    end else if (board_wr_en) begin
      ram[board_wr_addr] <= board_wr_data;
      wr_total <= wr_total + 1;
    end
    board_rd_data <= ram[board_rd_addr];
    if (board_rd_addr == 5'd20) rd20_total <= rd20_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_board();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic load_row(input logic [4:0] r, input logic [9:0] d);
    ld_en = 1'b1; ld_addr = r; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic set_piece(input logic [4:0] r, input logic [4:0] c,
                           input logic [4:0] v1, input logic [4:0] h1,
                           input logic [4:0] v2, input logic [4:0] h2,
                           input logic [4:0] v3, input logic [4:0] h3,
                           input logic [4:0] v4, input logic [4:0] h4);
    piece_row = r; piece_col = c;
    voff[0] = v1; hoff[0] = h1;
    voff[1] = v2; hoff[1] = h2;
    voff[2] = v3; hoff[2] = h3;
    voff[3] = v4; hoff[3] = h4;
  endtask

  // Pulse start, then count cycles until done (cycle 1 = first cycle after acceptance)
  task automatic run_op(input logic cm, input int stop_at, input bit repulse, output int dcyc);
    commit = cm;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcyc  = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        dcyc = c;
        break;
      end
      if (c == stop_at) break;
      if (repulse && c == 3) begin
        start = 1'b1;
        commit = 1'b1;
        set_piece(Z, Z, M1, M1, M1, M1, M1, M1, M1, M1);
      end else if (repulse && c == 4) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  int dcyc;
  int w0;
  int r0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      voff[i] = '0;
      hoff[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_done",    32'(done), 32'd0);
    check("rst_coll",    32'(collision), 32'd0);
    check("rst_wr_en",   32'(board_wr_en), 32'd0);
    check("rst_rd_addr", 32'(board_rd_addr), 32'd0);
    check("rst_wr_addr", 32'(board_wr_addr), 32'd0);
    check("rst_wr_data", 32'(board_wr_data), 32'd0);
    rst_n = 1'b1;
    clear_board();

    // 1: CHECK T piece on empty board
    set_piece(5'd5, 5'd4, Z, Z, Z, P1, Z, M1, P1, Z);
    w0 = wr_total;
    run_op(1'b0, 0, 1'b0, dcyc);
    check("t1_done_cyc", 32'(dcyc), 32'd13);
    check("t1_coll",     32'(collision), 32'd0);
    check("t1_no_wr",    32'(wr_total - w0), 32'd0);

    // 2: CHECK with blk4 landing on row 20 (below the floor)
    set_piece(5'd19, 5'd4, Z, Z, Z, P1, Z, M1, P1, Z);
    w0 = wr_total;
    r0 = rd20_total;
    run_op(1'b0, 0, 1'b0, dcyc);
    check("t2_done_cyc", 32'(dcyc), 32'd11);
    check("t2_coll",     32'(collision), 32'd1);
    check("t2_no_rd20",  32'(rd20_total - r0), 32'd0);
    check("t2_no_wr",    32'(wr_total - w0), 32'd0);

    // 3: CHECK hitting a settled cell on the first block -> early exit
    load_row(5'd6, 10'b0000010000);
    set_piece(5'd6, 5'd4, Z, Z, Z, P1, Z, M1, P1, Z);
    run_op(1'b0, 0, 1'b0, dcyc);
    check("t3_done_cyc", 32'(dcyc), 32'd4);
    check("t3_coll",     32'(collision), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t3_coll_hold", 32'(collision), 32'd1);
    check("t3_busy_low",  32'(busy), 32'd0);

    // 4: COMMIT horizontal I on floor row
    clear_board();
    set_piece(5'd19, 5'd4, Z, M1, Z, Z, Z, P1, Z, P2);
    w0 = wr_total;
    run_op(1'b1, 0, 1'b0, dcyc);
    check("t4_done_cyc", 32'(dcyc), 32'd17);
    check("t4_coll",     32'(collision), 32'd0);
    check("t4_wr_cnt",   32'(wr_total - w0), 32'd4);
    check("t4_row19",    32'(ram[19]), 32'h078);
    check("t4_row18",    32'(ram[18]), 32'h000);

    // 5: reset asserted during cycle 9 of a COMMIT (blk3 CALC)
    clear_board();
    set_piece(5'd10, 5'd2, Z, Z, Z, P1, Z, P2, Z, P3);
    w0 = wr_total;
    run_op(1'b1, 9, 1'b0, dcyc);
    rst_n = 1'b0;
    #1;
    check("t5_busy",  32'(busy), 32'd0);
    check("t5_done",  32'(done), 32'd0);
    check("t5_wr_en", 32'(board_wr_en), 32'd0);
    check("t5_coll",  32'(collision), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t5_wr_cnt", 32'(wr_total - w0), 32'd2);
    check("t5_row10",  32'(ram[10]), 32'h00C);
    @(posedge clk); #1;

    // 6: start re-pulsed while busy with OOB offsets -> ignored
    clear_board();
    set_piece(5'd5, 5'd4, Z, Z, Z, P1, Z, M1, P1, Z);
    w0 = wr_total;
    run_op(1'b0, 0, 1'b1, dcyc);
    check("t6_done_cyc", 32'(dcyc), 32'd13);
    check("t6_coll",     32'(collision), 32'd0);
    check("t6_no_wr",    32'(wr_total - w0), 32'd0);

    // 7: COMMIT with a duplicated cell
    clear_board();
    set_piece(5'd2, 5'd0, Z, Z, Z, Z, Z, P1, P1, Z);
    w0 = wr_total;
    run_op(1'b1, 0, 1'b0, dcyc);
    check("t7_done_cyc", 32'(dcyc), 32'd17);
    check("t7_coll",     32'(collision), 32'd1);
    check("t7_wr_cnt",   32'(wr_total - w0), 32'd4);
    check("t7_row2",     32'(ram[2]), 32'h003);
    check("t7_row3",     32'(ram[3]), 32'h001);

    // 8: COMMIT at origin with two out-of-bounds blocks skipped
    clear_board();
    set_piece(5'd0, 5'd0, Z, Z, M1, Z, Z, P1, Z, M1);
    w0 = wr_total;
    run_op(1'b1, 0, 1'b0, dcyc);
    check("t8_done_cyc", 32'(dcyc), 32'd11);
    check("t8_coll",     32'(collision), 32'd1);
    check("t8_wr_cnt",   32'(wr_total - w0), 32'd2);
    check("t8_row0",     32'(ram[0]), 32'h003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
